// File: rtl/code_seq_pkg.sv
// Shared mode encodings and constants for the code-sequence generator.
// Optional down-count support is selected in the top with CODE_SEQ_DOWN_EN.
package code_seq_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_BIN     = 3'd0;
  localparam mode_t MODE_BCD     = 3'd1;
  localparam mode_t MODE_GRAY    = 3'd2;
  localparam mode_t MODE_AIKEN   = 3'd3;
  localparam mode_t MODE_STIBITZ = 3'd4;

  localparam logic [3:0] DEC_DIGIT_MAX = 4'd9;

  // Decimal-class modes count 0..9 per digit; everything else (incl. reserved) is binary.
  function automatic logic is_dec_mode(mode_t m);
    return (m == MODE_BCD) || (m == MODE_AIKEN) || (m == MODE_STIBITZ);
  endfunction

endpackage

// File: rtl/code_digit_enc.sv
// Maps one decimal digit (0..9) to its BCD, Aiken or Stibitz (excess-3) code.
module code_digit_enc
  import code_seq_pkg::*;
(
  input  logic [3:0] digit_i,
  input  mode_t      mode_i,
  output logic [3:0] code_o
);

  always_comb begin
    code_o = digit_i;
    case (mode_i)
      MODE_AIKEN: begin
        if (digit_i > 4'd4) code_o = digit_i + 4'd6;
      end
      MODE_STIBITZ: code_o = digit_i + 4'd3;
      default: ;
    endcase
  end

endmodule

// File: rtl/code_seq_gen.sv
// Multi-digit binary/BCD/Gray/Aiken/Stibitz sequence generator.
// Define CODE_SEQ_DOWN_EN to honour up_i and build the down-count/borrow path.
module code_seq_gen
  import code_seq_pkg::*;
#(
  parameter int unsigned DIGITS = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                clr_i,
  input  logic                up_i,
  input  logic                wrap_i,
  input  mode_t               mode_i,
  output logic [4*DIGITS-1:0] code_o,
  output logic                at_end_o,
  output logic                wrapped_o
);

  localparam int unsigned W = 4 * DIGITS;
  localparam logic [W-1:0] CountOne = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_q, count_d;
  mode_t        mode_q, mode_d;
  logic         wrapped_q, wrapped_d;

  logic         is_dec;
  logic [W-1:0] dec_max, max_val;
  logic [W-1:0] bin_up, dec_up;
  logic         up_carry;
  logic [W-1:0] step_cnt;
  logic         step_wrap;

  assign is_dec = is_dec_mode(mode_q);

  always_comb begin
    dec_max = '0;
    for (int i = 0; i < int'(DIGITS); i++) dec_max[4*i +: 4] = DEC_DIGIT_MAX;
  end

  assign max_val = is_dec ? dec_max : {W{1'b1}};
  assign bin_up  = count_q + CountOne;

  // Per-digit ripple carry: a 9 rolls to 0 and passes the carry on.
  always_comb begin
    dec_up   = count_q;
    up_carry = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (up_carry) begin
        if (count_q[4*i +: 4] >= DEC_DIGIT_MAX) begin
          dec_up[4*i +: 4] = 4'd0;
        end else begin
          dec_up[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          up_carry         = 1'b0;
        end
      end
    end
  end

`ifdef CODE_SEQ_DOWN_EN
  logic [W-1:0] bin_dn, dec_dn;
  logic         dn_borrow;

  assign bin_dn = count_q - CountOne;

  always_comb begin
    dec_dn    = count_q;
    dn_borrow = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (dn_borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_dn[4*i +: 4] = DEC_DIGIT_MAX;
        end else begin
          dec_dn[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          dn_borrow        = 1'b0;
        end
      end
    end
  end

  assign at_end_o = up_i ? (count_q == max_val) : (count_q == '0);
`else
  logic unused_up;
  assign unused_up = up_i;
  assign at_end_o  = (count_q == max_val);
`endif

  always_comb begin
    step_cnt  = count_q;
    step_wrap = 1'b0;
`ifdef CODE_SEQ_DOWN_EN
    if (!up_i) begin
      if (count_q != '0) begin
        step_cnt = is_dec ? dec_dn : bin_dn;
      end else if (wrap_i) begin
        step_cnt  = max_val;
        step_wrap = 1'b1;
      end
    end else
`endif
    begin
      if (count_q != max_val) begin
        step_cnt = is_dec ? dec_up : bin_up;
      end else if (wrap_i) begin
        step_cnt  = '0;
        step_wrap = 1'b1;
      end
    end
  end

  // A mode change restarts the sequence and swallows any en on the same edge.
  always_comb begin
    count_d   = count_q;
    mode_d    = mode_q;
    wrapped_d = 1'b0;
    if (clr_i) begin
      count_d = '0;
    end else if (mode_i != mode_q) begin
      mode_d  = mode_i;
      count_d = '0;
    end else if (en_i) begin
      count_d   = step_cnt;
      wrapped_d = step_wrap;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q   <= '0;
      mode_q    <= mode_i;
      wrapped_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      mode_q    <= mode_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign wrapped_o = wrapped_q;

  logic [W-1:0] dec_code;

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
    code_digit_enc u_enc (
      .digit_i (count_q[4*g +: 4]),
      .mode_i  (mode_q),
      .code_o  (dec_code[4*g +: 4])
    );
  end

  always_comb begin
    if (is_dec) begin
      code_o = dec_code;
    end else if (mode_q == MODE_GRAY) begin
      code_o = count_q ^ (count_q >> 1);
    end else begin
      code_o = count_q;
    end
  end

endmodule

// File: tb/tb_code_seq_gen.sv
// Self-checking bench: DIGITS=1 and DIGITS=2 instances driven in lockstep against an
// integer-valued reference model. Honours CODE_SEQ_DOWN_EN if defined.
module tb_code_seq_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, clr, up, wrap;
  logic [2:0] mode;
  logic [3:0] code1;
  logic [7:0] code2;
  logic       at_end1, at_end2, wrapped1, wrapped2;

  int n_checks = 0;
  int n_fails  = 0;

`ifdef CODE_SEQ_DOWN_EN
  localparam bit DownEn = 1'b1;
`else
  localparam bit DownEn = 1'b0;
`endif

  code_seq_gen #(.DIGITS(1)) u_dut1 (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (en),
    .clr_i     (clr),
    .up_i      (up),
    .wrap_i    (wrap),
    .mode_i    (mode),
    .code_o    (code1),
    .at_end_o  (at_end1),
    .wrapped_o (wrapped1)
  );

  code_seq_gen #(.DIGITS(2)) u_dut2 (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (en),
    .clr_i     (clr),
    .up_i      (up),
    .wrap_i    (wrap),
    .mode_i    (mode),
    .code_o    (code2),
    .at_end_o  (at_end2),
    .wrapped_o (wrapped2)
  );

  // Reference model: count as a plain integer, index 0 -> 1 digit, index 1 -> 2 digits.
  int unsigned m_n[2];
  bit          m_wr[2];
  logic [2:0]  m_mode;

  function automatic bit is_dec(logic [2:0] m);
    return (m == 3'd1) || (m == 3'd3) || (m == 3'd4);
  endfunction

  function automatic int unsigned max_of(logic [2:0] m, int d);
    if (is_dec(m)) return (10 ** d) - 1;
    return (1 << (4 * d)) - 1;
  endfunction

  function automatic logic [15:0] enc(int unsigned n, logic [2:0] m, int d);
    int unsigned r, v, dig, e;
    r = 0;
    v = n;
    if (is_dec(m)) begin
      for (int k = 0; k < d; k++) begin
        dig = v % 10;
        v   = v / 10;
        if (m == 3'd3)      e = (dig < 5) ? dig : dig + 6;
        else if (m == 3'd4) e = dig + 3;
        else                e = dig;
        r = r | (e << (4 * k));
      end
    end else if (m == 3'd2) begin
      r = n ^ (n >> 1);
    end else begin
      r = n;
    end
    return r[15:0];
  endfunction

  function automatic bit dir_up();
    return DownEn ? up : 1'b1;
  endfunction

  task automatic model_edge();
    bit mchg;
    int unsigned mx;
    mchg = (mode != m_mode);
    for (int k = 0; k < 2; k++) begin
      mx = max_of(m_mode, k + 1);
      m_wr[k] = 1'b0;
      if (rst || clr || mchg) begin
        m_n[k] = 0;
      end else if (en) begin
        if (dir_up()) begin
          if (m_n[k] < mx) m_n[k] = m_n[k] + 1;
          else if (wrap) begin m_n[k] = 0; m_wr[k] = 1'b1; end
        end else begin
          if (m_n[k] > 0) m_n[k] = m_n[k] - 1;
          else if (wrap) begin m_n[k] = mx; m_wr[k] = 1'b1; end
        end
      end
    end
    if (rst || (!clr && mchg)) m_mode = mode;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic e1, e2;
    e1 = dir_up() ? (m_n[0] == max_of(m_mode, 1)) : (m_n[0] == 0);
    e2 = dir_up() ? (m_n[1] == max_of(m_mode, 2)) : (m_n[1] == 0);
    chk({tag, ".code1"},    {12'b0, code1},    enc(m_n[0], m_mode, 1));
    chk({tag, ".code2"},    {8'b0, code2},     enc(m_n[1], m_mode, 2));
    chk({tag, ".at_end1"},  {15'b0, at_end1},  {15'b0, e1});
    chk({tag, ".at_end2"},  {15'b0, at_end2},  {15'b0, e2});
    chk({tag, ".wrapped1"}, {15'b0, wrapped1}, {15'b0, m_wr[0]});
    chk({tag, ".wrapped2"}, {15'b0, wrapped2}, {15'b0, m_wr[1]});
  endtask

  task automatic cyc(input bit e, input bit c, input bit r, input bit u, input bit w,
                     input logic [2:0] md, input string tag);
    en   = e;
    clr  = c;
    rst  = r;
    up   = u;
    wrap = w;
    mode = md;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; up = 1'b1; wrap = 1'b0; mode = 3'd3;
    m_n = '{0, 0};
    m_wr = '{0, 0};
    m_mode = 3'd3;

    // Aiken, saturate
    cyc(0, 0, 1, 1, 0, 3'd3, "aiken_rst");
    chk("aiken_rst_code", {12'b0, code1}, 16'h0000);
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 1, 0, 3'd3, "aiken_run");
    chk("aiken_hold_code", {12'b0, code1}, 16'h000f);
    chk("aiken_hold_end", {15'b0, at_end1}, 16'h0001);

    // Stibitz, then wrap
    cyc(0, 0, 1, 1, 0, 3'd4, "stib_rst");
    chk("stib_rst_code", {12'b0, code1}, 16'h0003);
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, 1, 0, 3'd4, "stib_run");
    chk("stib_top_code", {12'b0, code1}, 16'h000c);
    cyc(1, 0, 0, 1, 1, 3'd4, "stib_wrap");
    chk("stib_wrap_code", {12'b0, code1}, 16'h0003);
    chk("stib_wrap_pulse", {15'b0, wrapped1}, 16'h0001);
    cyc(0, 0, 0, 1, 1, 3'd4, "stib_idle");

    // Gray
    cyc(0, 0, 1, 1, 0, 3'd2, "gray_rst");
    for (int i = 0; i < 15; i++) cyc(1, 0, 0, 1, 0, 3'd2, "gray_run");
    chk("gray_top_code", {12'b0, code1}, 16'h0008);

    // Two-digit BCD through 0x09 -> 0x10 and the 0x99 wrap
    cyc(0, 0, 1, 1, 1, 3'd1, "bcd_rst");
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 1, 1, 3'd1, "bcd_run");
    chk("bcd_carry_code", {8'b0, code2}, 16'h0010);
    for (int i = 0; i < 89; i++) cyc(1, 0, 0, 1, 1, 3'd1, "bcd_run");
    chk("bcd_top_code", {8'b0, code2}, 16'h0099);
    cyc(1, 0, 0, 1, 1, 3'd1, "bcd_wrap");
    chk("bcd_wrap_pulse", {15'b0, wrapped2}, 16'h0001);

    // Mode change with en: no step taken
    cyc(0, 0, 1, 1, 0, 3'd0, "mchg_rst");
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 1, 0, 3'd0, "mchg_run");
    cyc(1, 0, 0, 1, 0, 3'd1, "mchg_switch");
    chk("mchg_switch_code", {8'b0, code2}, 16'h0000);
    cyc(1, 0, 0, 1, 0, 3'd1, "mchg_step");
    chk("mchg_step_code", {8'b0, code2}, 16'h0001);

    // clr beats en
    cyc(1, 0, 0, 1, 0, 3'd1, "clr_pre");
    cyc(1, 1, 0, 1, 0, 3'd1, "clr_en");
    chk("clr_en_code", {8'b0, code2}, 16'h0000);

    // Down-count wrap (model treats up as 1 when the feature is absent)
    cyc(0, 0, 1, 0, 1, 3'd1, "down_rst");
    cyc(1, 0, 0, 0, 1, 3'd1, "down_wrap");
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1, 3'd1, "down_run");
    // Saturate at max with wrap=0, then flip direction
    cyc(0, 0, 1, 1, 0, 3'd0, "flip_rst");
    for (int i = 0; i < 18; i++) cyc(1, 0, 0, 1, 0, 3'd0, "flip_run");
    cyc(1, 0, 0, 0, 0, 3'd0, "flip_down");

    // Reset mid-run overrides everything else
    cyc(1, 1, 1, 1, 1, 3'd1, "rst_mid");
    chk("rst_mid_code", {8'b0, code2}, 16'h0000);

    // Randomized run
    for (int i = 0; i < 600; i++) begin
      logic [2:0] md;
      md = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : mode;
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, $urandom_range(0, 80) == 0,
          1'($urandom), 1'($urandom), md, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/code_seq_gen.md
# code_seq_gen

Parametrised, synthesizable code-sequence generator for the simulation/lab stimulus library. It steps through binary, BCD, Gray, Aiken or Stibitz (excess-3) sequences on a multi-digit word. The mode is selectable at run time, with enable, wrap-or-saturate behaviour and an optional down-count. It feeds decoders, 7-segment drivers and combinational blocks under test, both in benches and on hardware.

## Interface
- DIGITS, default 1: number of 4-bit digits; W = 4*DIGITS; legal range 1..4.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance one code step on this edge.
- clr  in  1  synchronous restart to the first code of the active mode.
- up  in  1  direction: 1 = up, 0 = down. Used only with CODE_SEQ_DOWN_EN.
- wrap  in  1  at the terminal code: 1 = wrap to the opposite end, 0 = hold (saturate).
- mode  in  3  code select; encodings are in the package.
- code  out  W  current code word.
- at_end  out  1  count is at the terminal value for the current direction.
- wrapped  out  1  one-cycle pulse after a wrap step.
- One clock; reset is synchronous and active-high.

## Operation
- State:
  - count_q: W-bit binary, or DIGITS decimal digits 0..9.
  - mode_q: 3 bits.
  - wrapped_q.
- Mode classes:
  - Binary class: BIN and GRAY. count runs 0..2^W-1.
  - Decimal class: BCD, AIKEN and STIBITZ. count runs 0..10^DIGITS-1 with per-digit ripple carry/borrow.
  - Reserved encodings 5..7 behave as BIN.
- Output encoding, from count_q and mode_q only:
  - BIN: code = count.
  - GRAY: code = count ^ (count >> 1).
  - BCD, per digit: code digit = d.
  - AIKEN, per digit: d < 5 gives d, otherwise d + 6.
  - STIBITZ, per digit: d + 3.
- Step priority per edge:
  1. rst: count_q = 0, mode_q = mode, wrapped_q = 0.
  2. clr: count_q = 0, wrapped_q = 0.
  3. mode != mode_q: mode_q = mode, count_q = 0, wrapped_q = 0. The en on this edge is ignored.
  4. en: take one step, described below.
  5. Otherwise hold; wrapped_q = 0.
- Step up:
  - If count < max, count + 1.
  - Else, if wrap = 1, count = 0 and wrapped_q = 1.
  - Else hold.
- Step down (macro only):
  - If count > 0, count - 1.
  - Else, if wrap = 1, count = max and wrapped_q = 1.
  - Else hold.
- max is 2^W-1 (binary class) or all-nines (decimal class).
- at_end is combinational from count_q, mode_q and the effective direction:
  - up: 1 when count = max.
  - down: 1 when count = 0.
- Saturated hold with en = 1 keeps at_end high and wrapped low.

## Timing
- Reset values:
  - code = first code of the mode sampled at reset: all zeros, except STIBITZ, which is 0011 per digit.
  - at_end = 0 when effective direction is up, else 1.
  - wrapped = 0.
- Latency:
  - en to new code: 1 cycle. code is valid from the edge after en is sampled high.
  - Mode change: code shows the new mode's first code 1 cycle after the change is sampled.
  - wrapped is high exactly one cycle, coincident with the post-wrap code.
- Sustained en = 1 gives one step per clock. No handshake; en needs no gaps.
- Boundary cases:
  - Reset mid-sequence overrides all other inputs in the same cycle.
  - clr together with en: clr wins, no step.
  - up toggled while at max with wrap = 0: the next en steps down normally (macro builds only).

## Configuration
- CODE_SEQ_DOWN_EN defined: up is honoured; down-count logic and borrow chain are built.
- Undefined:
  - Effective direction is always up; the up port is ignored (unconnected internally).
  - at_end means count = max.
  - No borrow logic is synthesised.

## Structure
- Package code_seq_pkg holds:
  - Mode localparams MODE_BIN=0, MODE_BCD=1, MODE_GRAY=2, MODE_AIKEN=3, MODE_STIBITZ=4.
  - The 3-bit mode typedef.
  - The decimal digit max constant (9).
- Sub-module code_digit_enc: combinational 4-bit digit plus mode in, encoded digit out. Instantiated DIGITS times for the decimal class.
- Gray conversion and binary count stay in the top.

## Test plan
- DIGITS=1, mode AIKEN, wrap=0, en held 12 cycles -> 0000,0001,0010,0011,0100,1011,1100,1101,1110,1111, then holds 1111 with at_end=1 and wrapped=0.
- DIGITS=1, mode STIBITZ -> reset code 0011; 9 steps reach 1100 with at_end=1; wrap=1 next step -> 0011 with wrapped=1 for one cycle.
- DIGITS=1, mode GRAY, 15 steps -> 0000,0001,0011,0010,0110,...,1001,1000; at_end=1 on 1000.
- DIGITS=2, mode BCD: step from 0x09 -> 0x10; from 0x99 with wrap=1 -> 0x00 with wrapped pulse.
- Mode changed BIN->BCD at count 0x0C with en=1 -> next code 0x00, no step taken; the following en gives 0x01.
- CODE_SEQ_DOWN_EN, DIGITS=2, BCD, up=0, wrap=1, from 0x00 -> 0x99 with wrapped=1; rst asserted mid-run -> 0x00 on the next edge.
